// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with count-based flags, thresholds and read-valid strobe.
// Optional sticky overflow/underflow error flags are built when FIFO_ERR_FLAGS_EN is defined.
module fifo_sync_param #(
  parameter int unsigned DATA_W    = 10,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned AFULL_TH  = 12,
  parameter int unsigned AEMPTY_TH = 2
) (
  input  logic              Pclk,
  input  logic              rst,
  input  logic              wr,
  input  logic              rd,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned     DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_C  = (ADDR_W+1)'(AFULL_TH);
  localparam logic [ADDR_W:0] AEMPTY_C = (ADDR_W+1)'(AEMPTY_TH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] w_ptr;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   count_next;
  logic              wa;
  logic              ra;

  // Acceptance uses the registered flags, so a read on an empty FIFO never bypasses.
  assign wa = wr & ~full;
  assign ra = rd & ~empty;

  always_comb begin
    count_next = count;
    if (wa && !ra)
      count_next = count + 1'b1;
    else if (ra && !wa)
      count_next = count - 1'b1;
  end

  always_ff @(posedge Pclk) begin
    if (wa && !rst)
      mem[w_ptr] <= data_in;
  end

  always_ff @(posedge Pclk) begin
    if (rst) begin
      w_ptr        <= '0;
      r_ptr        <= '0;
      count        <= '0;
      data_out     <= '0;
      valid_out    <= 1'b0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= (AFULL_TH == 0);
    end else begin
      if (wa)
        w_ptr <= w_ptr + 1'b1;
      if (ra) begin
        r_ptr    <= r_ptr + 1'b1;
        data_out <= mem[r_ptr];
      end
      valid_out    <= ra;
      count        <= count_next;
      empty        <= (count_next == '0);
      full         <= (count_next == DEPTH_C);
      almost_empty <= (count_next <= AEMPTY_C);
      almost_full  <= (count_next >= AFULL_C);
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  always_ff @(posedge Pclk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr && full && !ra)
        overflow <= 1'b1;
      if (rd && empty)
        underflow <= 1'b1;
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule
